// File: rtl/rose_guard_monitor.sv
// Multi-channel monitor: a periodic arm makes any rising edge on a masked-in channel in the following cycle a violation.
// Optional ROSE_GUARD_SVA_EN adds equivalent per-channel concurrent assertions plus an arm cover; outputs are unchanged.
module rose_guard_monitor #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8,
  parameter int PERIOD   = 2,
  parameter int MAX_CYC  = 10,
  parameter int ERR_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [CHANNELS-1:0] sig,
  input  logic [CHANNELS-1:0] mask,
  output logic [CNT_W-1:0]    cyc,
  output logic                arm,
  output logic [CHANNELS-1:0] viol,
  output logic [CHANNELS-1:0] err_sticky,
  output logic [ERR_W-1:0]    err_cnt,
  output logic                done
);

  localparam int PH_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int POP_W = $clog2(CHANNELS + 1);
  localparam int SUM_W = ERR_W + POP_W;
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] CYC_END = CNT_W'(MAX_CYC);
  localparam logic [SUM_W-1:0] ERR_MAX = {{POP_W{1'b0}}, {ERR_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_nxt;
  logic [PH_W-1:0]     phase, phase_nxt;
  logic [CNT_W-1:0]    cyc_nxt;
  logic                done_nxt;
  logic                arm_q;
  logic                smp_v;
  logic [CHANNELS-1:0] sig_q;
  logic [CHANNELS-1:0] rise;
  logic [POP_W-1:0]    pop;
  logic [SUM_W-1:0]    err_sum;
  logic [ERR_W-1:0]    err_nxt;

  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc;
    phase_nxt = phase;
    done_nxt  = done;
    case (state)
      IDLE: begin
        if (en) state_nxt = RUN;
      end
      RUN: begin
        if (!en) begin
          state_nxt = IDLE;
        end else begin
          cyc_nxt   = cyc + CNT_W'(1);
          phase_nxt = (phase == PH_LAST) ? '0 : phase + PH_W'(1);
          if (cyc_nxt == CYC_END) begin
            done_nxt  = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  assign arm  = en && (state == RUN) && (phase == PH_LAST);
  // smp_v suppresses a false edge against the reset value of sig_q.
  assign rise = sig & ~sig_q & {CHANNELS{smp_v}};

  always_comb begin
    pop = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pop = pop + POP_W'(viol[i]);
    end
    err_sum = SUM_W'(err_cnt) + SUM_W'(pop);
    err_nxt = (err_sum > ERR_MAX) ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cyc        <= '0;
      phase      <= '0;
      done       <= 1'b0;
      arm_q      <= 1'b0;
      sig_q      <= '0;
      smp_v      <= 1'b0;
      viol       <= '0;
      err_sticky <= '0;
      err_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      cyc        <= cyc_nxt;
      phase      <= phase_nxt;
      done       <= done_nxt;
      arm_q      <= arm;
      sig_q      <= sig;
      smp_v      <= 1'b1;
      // A pending arm is evaluated regardless of en or DONE.
      viol       <= {CHANNELS{arm_q}} & rise & mask;
      err_sticky <= err_sticky | viol;
      err_cnt    <= err_nxt;
    end
  end

`ifdef ROSE_GUARD_SVA_EN
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_sva
    a_no_rose_after_arm: assert property (
      @(posedge clk) disable iff (rst) arm |=> not ($rose(sig[gi]) && mask[gi]))
      else $error("rose_guard_monitor: channel %0d rose after arm at cyc %0d", gi, cyc);
  end

  c_arm: cover property (@(posedge clk) disable iff (rst) arm);
`else
  // Detection relies solely on the registered path above.
`endif

endmodule
